// File: rtl/corevx_cache_arbiter_if.sv
// corevx_cache_arbiter_if
//
// One corevx cache port: a command/request bundle travelling towards the
// cache and a response bundle travelling back. The same bundle describes
// the fetch requester port, the execute requester port and the cache port
// itself, so the arbiter is a slave on the two requester instances and a
// master on the cache instance.
//
// Signals:
//   c_cmd         request command, CACHE_CMD_* (master -> slave)
//   c_address     request address (master -> slave)
//   c_load_type   load type (master -> slave)
//   c_store_type  store type (master -> slave)
//   c_store_data  store data (master -> slave)
//   c_response    cache response, CACHE_RESPONSE_* (slave -> master)
//   c_load_data   load data (slave -> master)
//   c_reset_done  cache initialisation finished (slave -> master)
interface corevx_cache_arbiter_if;
    logic [3:0]  c_cmd;
    logic [31:0] c_address;
    logic [2:0]  c_load_type;
    logic [1:0]  c_store_type;
    logic [31:0] c_store_data;
    logic [3:0]  c_response;
    logic [31:0] c_load_data;
    logic        c_reset_done;

    // Side that issues commands and consumes responses.
    modport master (
        output c_cmd, c_address, c_load_type, c_store_type, c_store_data,
        input  c_response, c_load_data, c_reset_done
    );

    // Side that accepts commands and produces responses.
    modport slave (
        input  c_cmd, c_address, c_load_type, c_store_type, c_store_data,
        output c_response, c_load_data, c_reset_done
    );
endinterface

// File: rtl/corevx_cache_arbiter.sv
// corevx_cache_arbiter
//
// Shares the single corevx cache between the fetch and execute requesters.
// Each requester pulses a one-cycle command; the pulse is captured into a
// per-port pending slot, and slots are issued to the cache one at a time
// with round-robin priority. The cache response is routed only to the port
// owning the transaction in flight.
//
// Parameters:
//   RESET_PRIORITY  port winning the first simultaneous contention after
//                   reset (0 = fetch, 1 = execute)
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   f_c    fetch requester port (slave side)
//   e_c    execute requester port (slave side)
//   c      cache port (master side)
module corevx_cache_arbiter #(
    parameter logic RESET_PRIORITY = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    corevx_cache_arbiter_if.slave   f_c,
    corevx_cache_arbiter_if.slave   e_c,
    corevx_cache_arbiter_if.master  c
);

    localparam logic [3:0] CMD_NONE         = 4'd0;
    localparam logic [3:0] RESP_NONE        = 4'd0;
    localparam logic [3:0] RESP_DONE        = 4'd1;
    localparam logic [3:0] RESP_MISSALIGNED = 4'd2;
    localparam logic [3:0] RESP_ACCESSFAULT = 4'd3;
    localparam logic [3:0] RESP_PAGEFAULT   = 4'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_E = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  cmd;
        logic [31:0] address;
        logic [2:0]  loadType;
        logic [1:0]  storeType;
        logic [31:0] storeData;
    } slot_t;

    state_t r_state;
    logic   r_lastGrant;    // 0 = fetch, 1 = execute
    slot_t  r_slotF;
    slot_t  r_slotE;

    logic   w_terminal;
    logic   w_freeF;
    logic   w_freeE;
    logic   w_capF;
    logic   w_capE;
    logic   w_issue;
    logic   w_winnerE;
    logic   w_violF;
    logic   w_violE;

    always_comb begin
        w_terminal = (c.c_response == RESP_DONE)        ||
                     (c.c_response == RESP_MISSALIGNED) ||
                     (c.c_response == RESP_ACCESSFAULT) ||
                     (c.c_response == RESP_PAGEFAULT);
        w_freeF    = (r_state == BUSY_F) && w_terminal;
        w_freeE    = (r_state == BUSY_E) && w_terminal;
        // A slot being freed this cycle can take the same port's next pulse.
        w_capF     = (f_c.c_cmd != CMD_NONE) && (!r_slotF.valid || w_freeF);
        w_capE     = (e_c.c_cmd != CMD_NONE) && (!r_slotE.valid || w_freeE);
        w_violF    = (f_c.c_cmd != CMD_NONE) && r_slotF.valid && !w_freeF;
        w_violE    = (e_c.c_cmd != CMD_NONE) && r_slotE.valid && !w_freeE;
        w_issue    = (r_state == IDLE) && c.c_reset_done &&
                     (r_slotF.valid || r_slotE.valid);
        // Execute wins when it is alone, or when both wait and fetch went last.
        w_winnerE  = r_slotE.valid && (!r_slotF.valid || (r_lastGrant == 1'b0));
    end

    // Pending slots: capture has priority over the free of the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slotF <= '0;
            r_slotE <= '0;
        end else begin
            if (w_capF) begin
                r_slotF <= {1'b1, f_c.c_cmd, f_c.c_address, f_c.c_load_type,
                            f_c.c_store_type, f_c.c_store_data};
            end else if (w_freeF) begin
                r_slotF.valid <= 1'b0;
            end
            if (w_capE) begin
                r_slotE <= {1'b1, e_c.c_cmd, e_c.c_address, e_c.c_load_type,
                            e_c.c_store_type, e_c.c_store_data};
            end else if (w_freeE) begin
                r_slotE.valid <= 1'b0;
            end
        end
    end

    // Ownership state machine and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lastGrant <= ~RESET_PRIORITY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state     <= w_winnerE ? BUSY_E : BUSY_F;
                        r_lastGrant <= w_winnerE;
                    end
                end
                BUSY_F, BUSY_E: begin
                    if (w_terminal) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The command goes out in the same cycle the slot is seen valid, so the
    // cache-side and requester-side outputs are decoded from state and slots
    // rather than registered; this keeps the arbiter at one cycle of latency.
    always_comb begin
        c.c_cmd          = CMD_NONE;
        c.c_address      = '0;
        c.c_load_type    = '0;
        c.c_store_type   = '0;
        c.c_store_data   = '0;
        f_c.c_response   = RESP_NONE;
        f_c.c_load_data  = '0;
        e_c.c_response   = RESP_NONE;
        e_c.c_load_data  = '0;
        f_c.c_reset_done = c.c_reset_done;
        e_c.c_reset_done = c.c_reset_done;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    c.c_cmd        = w_winnerE ? r_slotE.cmd       : r_slotF.cmd;
                    c.c_address    = w_winnerE ? r_slotE.address   : r_slotF.address;
                    c.c_load_type  = w_winnerE ? r_slotE.loadType  : r_slotF.loadType;
                    c.c_store_type = w_winnerE ? r_slotE.storeType : r_slotF.storeType;
                    c.c_store_data = w_winnerE ? r_slotE.storeData : r_slotF.storeData;
                end
            end
            BUSY_F: begin
                c.c_address     = r_slotF.address;
                c.c_load_type   = r_slotF.loadType;
                c.c_store_type  = r_slotF.storeType;
                c.c_store_data  = r_slotF.storeData;
                f_c.c_response  = c.c_response;
                f_c.c_load_data = c.c_load_data;
            end
            BUSY_E: begin
                c.c_address     = r_slotE.address;
                c.c_load_type   = r_slotE.loadType;
                c.c_store_type  = r_slotE.storeType;
                c.c_store_data  = r_slotE.storeData;
                e_c.c_response  = c.c_response;
                e_c.c_load_data = c.c_load_data;
            end
            default: begin
            end
        endcase
    end

    // A second pulse while the port's slot is still occupied is dropped.
    a_noFetchOverrun: assert property (@(posedge clk) disable iff (!rst_n) !w_violF);
    a_noExecOverrun:  assert property (@(posedge clk) disable iff (!rst_n) !w_violE);

endmodule

// File: tb/tb_corevx_cache_arbiter.sv
// tb_corevx_cache_arbiter
//
// Drives the arbiter with directed scenarios and a long random phase. A
// transaction-level reference (pending request per port, current owner,
// last grant) and a small cache responder predict every output each cycle.
module tb_corevx_cache_arbiter;

    localparam logic [3:0] CMD_NONE         = 4'd0;
    localparam logic [3:0] CMD_LOAD         = 4'd1;
    localparam logic [3:0] CMD_STORE        = 4'd2;
    localparam logic [3:0] RESP_NONE        = 4'd0;
    localparam logic [3:0] RESP_DONE        = 4'd1;
    localparam logic [3:0] RESP_PAGEFAULT   = 4'd4;
    localparam logic [3:0] RESP_WAIT        = 4'd5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    corevx_cache_arbiter_if fBus();
    corevx_cache_arbiter_if eBus();
    corevx_cache_arbiter_if cBus();

    corevx_cache_arbiter #(.RESET_PRIORITY(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .f_c   (fBus),
        .e_c   (eBus),
        .c     (cBus)
    );

    int assertCount = 0;
    int failCount   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference state: one pending request per port (0 fetch, 1 execute),
    // the port that owns the cache (-1 none) and the port granted last.
    typedef struct {
        bit          v;
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] sd;
    } req_t;

    req_t mPend[2];
    int   mOwner;
    int   mLast;

    // Cache responder: answers cLat cycles after an issue.
    bit          cBusy;
    int          cCount;
    int          cLat     = 3;
    logic [3:0]  cTerm    = RESP_DONE;
    logic [31:0] cData    = 32'hDEADBEEF;
    bit          noise    = 1'b0;
    bit          randMode = 1'b0;
    logic [31:0] dirData  = 32'h12345678;

    logic [3:0]  obsCmd;
    logic [31:0] obsAddr;
    logic [31:0] obsSd;
    logic [3:0]  obsFResp;
    logic [3:0]  obsEResp;
    logic [31:0] obsEData;

    function automatic bit isTerminal(input logic [3:0] r);
        return (r >= RESP_DONE) && (r <= RESP_PAGEFAULT);
    endfunction

    task automatic modelReset();
        mPend[0].v = 1'b0;
        mPend[1].v = 1'b0;
        mOwner     = -1;
        mLast      = 0;
        cBusy      = 1'b0;
        cCount     = 0;
    endtask

    // One clock cycle: drive cache and requesters, predict, check, update.
    task automatic applyStimulus(input logic [3:0] fCmd, input logic [31:0] fAddr,
                                 input logic [3:0] eCmd, input logic [31:0] eAddr,
                                 input logic rd);
        logic [3:0]  cmdIn [2];
        logic [31:0] addrIn[2];
        logic [2:0]  ltIn  [2];
        logic [1:0]  stIn  [2];
        logic [31:0] sdIn  [2];
        logic [3:0]  resp;
        logic [31:0] data;
        logic [3:0]  expCmd;
        logic [31:0] expAddr, expSd;
        logic [2:0]  expLt;
        logic [1:0]  expSt;
        logic [3:0]  expResp[2];
        logic [31:0] expData[2];
        int          freeing;
        int          win;
        bit          issueNow;

        @(posedge clk);
        #1;
        if (cBusy) begin
            cCount--;
            if (cCount == 0) begin
                resp  = cTerm;
                data  = cData;
                cBusy = 1'b0;
            end else begin
                resp = ($urandom_range(0, 1) == 1) ? RESP_WAIT : RESP_NONE;
                data = $urandom;
            end
        end else if (noise) begin
            resp = 4'($urandom_range(0, 5));
            data = $urandom;
        end else begin
            resp = RESP_NONE;
            data = '0;
        end
        cBus.c_response  = resp;
        cBus.c_load_data = data;
        cBus.c_reset_done = rd;
        freeing = (mOwner >= 0 && isTerminal(resp)) ? mOwner : -1;

        cmdIn[0] = fCmd; addrIn[0] = fAddr;
        cmdIn[1] = eCmd; addrIn[1] = eAddr;
        for (int p = 0; p < 2; p++) begin
            ltIn[p] = 3'($urandom);
            stIn[p] = 2'($urandom);
            sdIn[p] = dirData;
            if (randMode) begin
                cmdIn[p] = CMD_NONE;
                if ((!mPend[p].v || freeing == p) && $urandom_range(0, 99) < 35)
                    cmdIn[p] = 4'($urandom_range(1, 2));
                addrIn[p] = $urandom;
                sdIn[p]   = $urandom;
            end
        end
        fBus.c_cmd = cmdIn[0]; fBus.c_address = addrIn[0];
        fBus.c_load_type = ltIn[0]; fBus.c_store_type = stIn[0]; fBus.c_store_data = sdIn[0];
        eBus.c_cmd = cmdIn[1]; eBus.c_address = addrIn[1];
        eBus.c_load_type = ltIn[1]; eBus.c_store_type = stIn[1]; eBus.c_store_data = sdIn[1];

        expCmd = CMD_NONE; expAddr = '0; expLt = '0; expSt = '0; expSd = '0;
        expResp[0] = RESP_NONE; expResp[1] = RESP_NONE;
        expData[0] = '0; expData[1] = '0;
        issueNow = 1'b0;
        win = 0;
        if (mOwner < 0) begin
            if (rd && (mPend[0].v || mPend[1].v)) begin
                win = (mPend[0].v && mPend[1].v) ? 1 - mLast : (mPend[1].v ? 1 : 0);
                issueNow = 1'b1;
                expCmd = mPend[win].cmd; expAddr = mPend[win].addr;
                expLt = mPend[win].lt; expSt = mPend[win].st; expSd = mPend[win].sd;
            end
        end else begin
            expAddr = mPend[mOwner].addr; expLt = mPend[mOwner].lt;
            expSt = mPend[mOwner].st; expSd = mPend[mOwner].sd;
            expResp[mOwner] = resp;
            expData[mOwner] = data;
        end

        @(negedge clk);
        checkOutput("c_cmd",          cBus.c_cmd,        expCmd);
        checkOutput("c_address",      cBus.c_address,    expAddr);
        checkOutput("c_load_type",    cBus.c_load_type,  expLt);
        checkOutput("c_store_type",   cBus.c_store_type, expSt);
        checkOutput("c_store_data",   cBus.c_store_data, expSd);
        checkOutput("f_c_response",   fBus.c_response,   expResp[0]);
        checkOutput("f_c_load_data",  fBus.c_load_data,  expData[0]);
        checkOutput("e_c_response",   eBus.c_response,   expResp[1]);
        checkOutput("e_c_load_data",  eBus.c_load_data,  expData[1]);
        checkOutput("f_c_reset_done", fBus.c_reset_done, rd);
        checkOutput("e_c_reset_done", eBus.c_reset_done, rd);
        obsCmd = cBus.c_cmd; obsAddr = cBus.c_address; obsSd = cBus.c_store_data;
        obsFResp = fBus.c_response; obsEResp = eBus.c_response; obsEData = eBus.c_load_data;

        for (int p = 0; p < 2; p++) begin
            if (cmdIn[p] != CMD_NONE && (!mPend[p].v || freeing == p)) begin
                mPend[p].v = 1'b1; mPend[p].cmd = cmdIn[p]; mPend[p].addr = addrIn[p];
                mPend[p].lt = ltIn[p]; mPend[p].st = stIn[p]; mPend[p].sd = sdIn[p];
            end else if (freeing == p) begin
                mPend[p].v = 1'b0;
            end
        end
        if (issueNow) begin
            mOwner = win;
            mLast  = win;
            cBusy  = 1'b1;
            cCount = cLat;
            if (randMode) begin
                cCount = $urandom_range(1, 4);
                cTerm  = 4'($urandom_range(1, 4));
                cData  = $urandom;
            end
        end else if (freeing >= 0) begin
            mOwner = -1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(CMD_NONE, 0, CMD_NONE, 0, 1'b1);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        fBus.c_cmd = CMD_NONE; eBus.c_cmd = CMD_NONE; cBus.c_response = RESP_NONE;
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fBus.c_cmd = CMD_NONE; fBus.c_address = '0; fBus.c_load_type = '0;
        fBus.c_store_type = '0; fBus.c_store_data = '0;
        eBus.c_cmd = CMD_NONE; eBus.c_address = '0; eBus.c_load_type = '0;
        eBus.c_store_type = '0; eBus.c_store_data = '0;
        cBus.c_response = RESP_NONE; cBus.c_load_data = '0; cBus.c_reset_done = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset c_cmd",        cBus.c_cmd,        CMD_NONE);
        checkOutput("reset c_address",    cBus.c_address,    0);
        checkOutput("reset f_c_response", fBus.c_response,   RESP_NONE);
        checkOutput("reset e_c_load_data",eBus.c_load_data,  0);
        checkOutput("reset reset_done",   eBus.c_reset_done, 1);
        rst_n = 1'b1;

        $display("[TB] execute load with three-cycle cache latency");
        cLat = 3; cTerm = RESP_DONE; cData = 32'hDEADBEEF;
        applyStimulus(CMD_NONE, 0, CMD_LOAD, 32'h1000, 1'b1);
        applyStimulus(CMD_NONE, 0, CMD_NONE, 0, 1'b1);
        checkOutput("t1 issue cmd",  obsCmd,  CMD_LOAD);
        checkOutput("t1 issue addr", obsAddr, 32'h1000);
        idle(3);
        checkOutput("t1 e_resp", obsEResp, RESP_DONE);
        checkOutput("t1 e_data", obsEData, 32'hDEADBEEF);
        checkOutput("t1 f_resp", obsFResp, RESP_NONE);
        idle(1);

        $display("[TB] simultaneous pulses after reset");
        resetDut();
        cLat = 2;
        applyStimulus(CMD_LOAD, 32'h2000, CMD_STORE, 32'h3000, 1'b1);
        applyStimulus(CMD_NONE, 0, CMD_NONE, 0, 1'b1);
        checkOutput("t2 first cmd",  obsCmd,  CMD_STORE);
        checkOutput("t2 first addr", obsAddr, 32'h3000);
        checkOutput("t2 first data", obsSd,   32'h12345678);
        idle(2);
        checkOutput("t2 exec done", obsEResp, RESP_DONE);
        idle(1);
        checkOutput("t2 second cmd",  obsCmd,  CMD_LOAD);
        checkOutput("t2 second addr", obsAddr, 32'h2000);
        idle(2);
        applyStimulus(CMD_NONE, 0, CMD_LOAD, 32'h3100, 1'b1);
        idle(3);
        applyStimulus(CMD_LOAD, 32'h5000, CMD_LOAD, 32'h5100, 1'b1);
        idle(1);
        checkOutput("t2 rr addr", obsAddr, 32'h5000);
        idle(6);

        $display("[TB] fetch waits behind busy execute");
        cLat = 4;
        applyStimulus(CMD_NONE, 0, CMD_LOAD, 32'h6000, 1'b1);
        idle(1);
        applyStimulus(CMD_LOAD, 32'h7000, CMD_NONE, 0, 1'b1);
        checkOutput("t3 hold 1", obsCmd, CMD_NONE);
        idle(2);
        checkOutput("t3 hold 3", obsCmd, CMD_NONE);
        idle(1);
        checkOutput("t3 terminal", obsEResp, RESP_DONE);
        idle(1);
        checkOutput("t3 fetch cmd",  obsCmd,  CMD_LOAD);
        checkOutput("t3 fetch addr", obsAddr, 32'h7000);
        idle(5);

        $display("[TB] page fault on execute");
        cLat = 2; cTerm = RESP_PAGEFAULT;
        applyStimulus(CMD_NONE, 0, CMD_LOAD, 32'h4000, 1'b1);
        idle(3);
        checkOutput("t4 pagefault", obsEResp, RESP_PAGEFAULT);
        cTerm = RESP_DONE;
        applyStimulus(CMD_NONE, 0, CMD_LOAD, 32'h4100, 1'b1);
        checkOutput("t4 idle after fault", obsCmd, CMD_NONE);
        idle(1);
        checkOutput("t4 reissue addr", obsAddr, 32'h4100);
        idle(3);

        $display("[TB] requests before cache initialisation");
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i == 1) ? CMD_LOAD : CMD_NONE, 32'h8000,
                          (i == 3) ? CMD_STORE : CMD_NONE, 32'h9000, 1'b0);
            checkOutput("t5 no issue", obsCmd, CMD_NONE);
        end
        applyStimulus(CMD_NONE, 0, CMD_NONE, 0, 1'b1);
        checkOutput("t5 first issue", obsCmd != CMD_NONE, 1);
        idle(8);

        $display("[TB] reset during execute transaction");
        cLat = 4;
        applyStimulus(CMD_NONE, 0, CMD_LOAD, 32'hA000, 1'b1);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 async c_cmd",   cBus.c_cmd,        CMD_NONE);
        checkOutput("t6 async c_addr",  cBus.c_address,    0);
        checkOutput("t6 async e_resp",  eBus.c_response,   RESP_NONE);
        checkOutput("t6 async e_data",  eBus.c_load_data,  0);
        checkOutput("t6 async rdone",   fBus.c_reset_done, 1);
        modelReset();
        cBus.c_response = RESP_NONE;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        checkOutput("t6 no reissue", obsCmd, CMD_NONE);

        $display("[TB] random traffic");
        randMode = 1'b1; noise = 1'b1;
        for (int i = 0; i < 3000; i++)
            applyStimulus(CMD_NONE, 0, CMD_NONE, 0, ($urandom_range(0, 19) != 0));
        randMode = 1'b0; noise = 1'b0;
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
